uart_tx_frame: RTL
==================

# uart_tx_frame

- Transmit-side UART framer in the UART block: serialises one parallel data word into a start / data / parity / stop frame.
- Parity generation is consistent with the receive-side parity checker: even parity = XOR of data bits; odd parity = XNOR.
- Runs in the UART TX clock domain at one bit per CLK cycle; any oversampling or prescaling is done upstream.

## Interface
- DATA_WIDTH, 8, data bits per frame (≥ 2); bit counter is $clog2(DATA_WIDTH) bits wide.
- CLK  input  1  TX bit clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  parallel word to transmit; sampled only on acceptance.
- DATA_VALID  input  1  request to send P_DATA; single-cycle or level.
- PAR_EN  input  1  1 = parity bit inserted after data bits; sampled on acceptance.
- PAR_TYP  input  1  0 = even, 1 = odd; sampled on acceptance.
- STOP2  input  1  present only with UART_TX_STOP2_EN; 1 = two stop bits; sampled on acceptance.
- TX_OUT  output  1  serial line; registered; idles high.
- BUSY  output  1  registered; high while a frame is on the line.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, BUSY=0.
  - DATA_VALID=1 sampled in IDLE means the request is accepted.
  - On acceptance, latch P_DATA, PAR_EN, PAR_TYP and STOP2.
  - Parity is computed from the latched word: even = ^P_DATA, odd = ~^P_DATA.
  - Go to START.
- START: TX_OUT=0 for 1 cycle, then go to DATA. Bit counter = 0.
- DATA: drive latched data LSB first, one bit per cycle.
  - After bit DATA_WIDTH-1, go to PARITY if the latched PAR_EN=1, else go to STOP.
- PARITY: drive the latched parity bit for 1 cycle, then go to STOP.
- STOP: TX_OUT=1 for 1 cycle (2 cycles if the latched STOP2=1), then go to IDLE.
- BUSY=1 in every state except IDLE.
- DATA_VALID is ignored in every state except IDLE. It is not queued.
- Changes on P_DATA, PAR_EN, PAR_TYP or STOP2 after acceptance do not affect the frame in flight.
- Acceptance happens only in IDLE, so back-to-back frames are separated by at least 1 idle-high cycle.
- Reset values: TX_OUT=1, BUSY=0, state=IDLE, counter=0, latches=0.
- RST low mid-frame aborts immediately (asynchronous): TX_OUT=1 and BUSY=0 with no clock required. After release, the block waits in IDLE for a new request.

## Timing
- DATA_VALID high at edge k → at edge k+1, TX_OUT=0 and BUSY=1.
- Frame length in cycles = 1 + DATA_WIDTH + PAR_EN + stop bits. For DATA_WIDTH=8: 10, 11, or 12 with STOP2 and parity.
- BUSY is high for exactly the frame length, and falls on the same edge where TX_OUT enters IDLE.
- Earliest next acceptance is at the edge ending the first IDLE cycle. Minimum period = frame length + 1.
- Both outputs come straight from flops, so TX_OUT is glitch-free.

## Configuration
- UART_TX_STOP2_EN defined: the STOP2 port exists, and the latched STOP2=1 gives two stop cycles.
- UART_TX_STOP2_EN undefined: no STOP2 port, always one stop cycle, and the stop-count logic is removed.

## Structure
- Shared package uart_pkg holds:
  - state enum typedef (IDLE, START, DATA, PARITY, STOP);
  - constants PAR_EVEN=1'b0, PAR_ODD=1'b1;
  - constants START_BIT=1'b0, STOP_BIT=1'b1 / idle level.
- One sub-module, uart_tx_par_gen: parity of DATA_WIDTH bits per PAR_TYP. It is instantiated once and feeds the parity latch.
- The FSM, counter and shift register live in uart_tx_frame.

## Test plan
- P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0 → TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 (parity 0); BUSY high for 11 cycles.
- P_DATA=8'hA5, PAR_EN=1, PAR_TYP=1 → parity bit = 1; other bits as above; 11 cycles.
- P_DATA=8'hFF, PAR_EN=0 → 0, then 1×9; BUSY high for 10 cycles; next DATA_VALID is accepted no earlier than 1 idle cycle after BUSY falls.
- Accept 8'h01 (odd parity). At DATA bit 3, drive DATA_VALID=1 with P_DATA=8'h00 → the frame continues unchanged, parity bit = 0, and there is no second frame.
- RST low during DATA bit 4 of 8'h3C → TX_OUT=1 and BUSY=0 before the next edge. After release with DATA_VALID=0, the line stays high.
- With UART_TX_STOP2_EN defined: 8'h55, PAR_EN=1, PAR_TYP=0, STOP2=1 → 12-cycle frame ending with 1,1 stop bits (parity 0).

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit path: frame state encoding,
// parity-type selectors and the fixed line levels used by the framer.

package uart_pkg;

    // Frame states, in the order they appear on the line
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_e;

    // Parity type selector values
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Line levels: the stop bit and the idle line share the same level
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_par_gen.sv
// uart_tx_par_gen
// Combinational parity generator for one transmit word. Even parity is the
// XOR of the data bits, odd parity its complement, matching the receive-side
// checker.

module uart_tx_par_gen
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    // Parity of the word according to the selected type
    always_comb begin
        par_bit = ^data;
        if (par_typ == PAR_ODD) begin
            par_bit = ~^data;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
// Transmit framer: accepts one parallel word while idle and shifts it out as
// start / data (LSB first) / optional parity / stop, one bit per CLK.
// Optional feature macro: UART_TX_STOP2_EN adds the STOP2 port and support
// for two stop bits; without it every frame has exactly one stop bit.

module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
`ifdef UART_TX_STOP2_EN
    input  logic                  STOP2,
`endif
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_START  = START;
    localparam logic [2:0] ST_DATA   = DATA;
    localparam logic [2:0] ST_PARITY = PARITY;
    localparam logic [2:0] ST_STOP   = STOP;

    logic [2:0]            state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_bit;
    logic                  par_en_lat;
    logic                  par_calc;
    logic                  accept;
`ifdef UART_TX_STOP2_EN
    logic                  stop2_lat;
    logic                  stop_second;
`endif

    // A request only counts while the line is idle; it is never queued
    assign accept = (state == ST_IDLE) && DATA_VALID;

    uart_tx_par_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_par_gen (
        .data    (P_DATA),
        .par_typ (PAR_TYP),
        .par_bit (par_calc)
    );

    // Frame latches: capture word, parity and options at acceptance, then
    // shift the word right so bit 0 always holds the bit currently sent
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_reg  <= '0;
            par_bit    <= 1'b0;
            par_en_lat <= 1'b0;
`ifdef UART_TX_STOP2_EN
            stop2_lat  <= 1'b0;
`endif
        end else if (accept) begin
            shift_reg  <= P_DATA;
            par_bit    <= par_calc;
            par_en_lat <= PAR_EN;
`ifdef UART_TX_STOP2_EN
            stop2_lat  <= STOP2;
`endif
        end else if (state == ST_DATA && bit_cnt != LAST_BIT) begin
            shift_reg <= shift_reg >> 1;
        end
    end

    // Frame sequencer; TX_OUT and BUSY are loaded with the value of the
    // state being entered so both leave the block straight from flops
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            TX_OUT      <= IDLE_LEVEL;
            BUSY        <= 1'b0;
`ifdef UART_TX_STOP2_EN
            stop_second <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (DATA_VALID) begin
                        state   <= ST_START;
                        bit_cnt <= '0;
                        TX_OUT  <= START_BIT;
                        BUSY    <= 1'b1;
`ifdef UART_TX_STOP2_EN
                        stop_second <= 1'b0;
`endif
                    end else begin
                        TX_OUT <= IDLE_LEVEL;
                        BUSY   <= 1'b0;
                    end
                end

                ST_START: begin
                    state   <= ST_DATA;
                    bit_cnt <= '0;
                    TX_OUT  <= shift_reg[0];
                end

                ST_DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        if (par_en_lat) begin
                            state  <= ST_PARITY;
                            TX_OUT <= par_bit;
                        end else begin
                            state  <= ST_STOP;
                            TX_OUT <= STOP_BIT;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        TX_OUT  <= shift_reg[1];
                    end
                end

                ST_PARITY: begin
                    state  <= ST_STOP;
                    TX_OUT <= STOP_BIT;
                end

                ST_STOP: begin
`ifdef UART_TX_STOP2_EN
                    if (stop2_lat && !stop_second) begin
                        stop_second <= 1'b1;
                        TX_OUT      <= STOP_BIT;
                    end else begin
                        stop_second <= 1'b0;
                        state       <= ST_IDLE;
                        TX_OUT      <= IDLE_LEVEL;
                        BUSY        <= 1'b0;
                    end
`else
                    state  <= ST_IDLE;
                    TX_OUT <= IDLE_LEVEL;
                    BUSY   <= 1'b0;
`endif
                end

                default: begin
                    state   <= ST_IDLE;
                    bit_cnt <= '0;
                    TX_OUT  <= IDLE_LEVEL;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule
